// File: rtl/clock.sv
// Seconds-countdown step unit: divides clk down to a one-second tick and
// registers the next remaining-seconds value from the externally held
// rest_time. stop pauses the prescaler, dis clears both prescaler and output.
module clock #(
    parameter int TICK_DIV = 100000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] rest_time,
    output logic [4:0] next_time,
    input  logic       stop,
    input  logic       dis
);

    // A TICK_DIV of 2 still needs one prescaler bit.
    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PCNT_MAX = PW'(TICK_DIV - 1);

    logic [PW-1:0] pcnt_q;
    logic [PW-1:0] pcnt_d;
    logic [4:0]    next_time_q;
    logic [4:0]    next_time_d;
    logic          tick;

    // Decrement that saturates at zero instead of wrapping to 31.
    function automatic logic [4:0] sat_dec(input logic [4:0] v);
        if (v == 5'd0) begin
            return 5'd0;
        end
        return v - 5'd1;
    endfunction

    // Tick, prescaler and next-time selection in priority order dis > stop > normal.
    always_comb begin
        tick        = (pcnt_q == PCNT_MAX) && !stop && !dis;
        pcnt_d      = pcnt_q;
        next_time_d = rest_time;
        if (dis) begin
            pcnt_d      = '0;
            next_time_d = 5'd0;
        end else if (stop) begin
            pcnt_d      = pcnt_q;
            next_time_d = rest_time;
        end else begin
            pcnt_d      = (pcnt_q == PCNT_MAX) ? '0 : pcnt_q + PW'(1);
            next_time_d = tick ? sat_dec(rest_time) : rest_time;
        end
    end

    // State registers with synchronous reset taking precedence over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt_q      <= '0;
            next_time_q <= 5'd0;
        end else begin
            pcnt_q      <= pcnt_d;
            next_time_q <= next_time_d;
        end
    end

    assign next_time = next_time_q;

endmodule

// File: tb/tb_clock.sv
// Testbench for clock: directed scenarios plus randomized stimulus, all
// checked against a behavioural model that counts enabled edges since the
// last restart and ticks on every TICK_DIV-th one.
module tb_clock;

    localparam int TD = 4;

    logic       clk;
    logic       rst;
    logic [4:0] rest_time;
    logic [4:0] next_time;
    logic       stop;
    logic       dis;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int         en_edges = 0;
    logic [4:0] exp_next = 5'd0;

    clock #(.TICK_DIV(TD)) dut (
        .clk       (clk),
        .rst       (rst),
        .rest_time (rest_time),
        .next_time (next_time),
        .stop      (stop),
        .dis       (dis)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, advance the model, and compare.
    task automatic step(input string tag, input logic r, input logic d,
                        input logic s, input logic [4:0] rt);
        @(negedge clk);
        rst       = r;
        dis       = d;
        stop      = s;
        rest_time = rt;
        @(posedge clk);
        if (r || d) begin
            en_edges = 0;
            exp_next = 5'd0;
        end else if (s) begin
            exp_next = rt;
        end else begin
            en_edges++;
            if (en_edges % TD == 0)
                exp_next = (rt == 5'd0) ? 5'd0 : 5'(rt - 5'd1);
            else
                exp_next = rt;
        end
        #1;
        chk(tag, next_time, exp_next);
    endtask

    initial begin
        logic [4:0] reset_tbl [8];
        logic [4:0] fb;
        logic       r, d, s;
        logic       feedback;

        reset_tbl = '{5'd10, 5'd10, 5'd10, 5'd9, 5'd10, 5'd10, 5'd10, 5'd9};
        rst = 1'b1; dis = 1'b0; stop = 1'b0; rest_time = 5'd10;

        // Reset: two cycles held, then the tick pattern from a full second
        step("reset", 1'b1, 1'b0, 1'b0, 5'd10);
        step("reset", 1'b1, 1'b0, 1'b0, 5'd10);
        chk("reset_zero", next_time, 5'd0);
        for (int i = 0; i < 8; i++) begin
            step("after_reset", 1'b0, 1'b0, 1'b0, 5'd10);
            chk("reset_tbl", next_time, reset_tbl[i]);
        end

        // Feedback countdown from 3 with saturation at 0
        step("fb_clear", 1'b0, 1'b1, 1'b0, 5'd3);
        fb = 5'd3;
        for (int i = 0; i < 24; i++) begin
            step("feedback", 1'b0, 1'b0, 1'b0, fb);
            fb = next_time;
            if (i == 3)  chk("fb_2", next_time, 5'd2);
            if (i == 7)  chk("fb_1", next_time, 5'd1);
            if (i == 11) chk("fb_0", next_time, 5'd0);
        end
        chk("fb_sat", next_time, 5'd0);

        // Stop mid-second: pcnt=2, stop 6 cycles, tick on 2nd edge after
        step("stop_clr", 1'b0, 1'b1, 1'b0, 5'd10);
        step("stop_pre", 1'b0, 1'b0, 1'b0, 5'd10);
        step("stop_pre", 1'b0, 1'b0, 1'b0, 5'd10);
        for (int i = 0; i < 6; i++) begin
            step("stop_hold", 1'b0, 1'b0, 1'b1, 5'd10);
            chk("stop_val", next_time, 5'd10);
        end
        step("stop_rel1", 1'b0, 1'b0, 1'b0, 5'd10);
        chk("stop_rel1_c", next_time, 5'd10);
        step("stop_rel2", 1'b0, 1'b0, 1'b0, 5'd10);
        chk("stop_rel2_c", next_time, 5'd9);

        // Disable: 3 cycles, then first 19 on the 4th edge
        for (int i = 0; i < 3; i++) begin
            step("dis_hold", 1'b0, 1'b1, 1'b0, 5'd20);
            chk("dis_zero", next_time, 5'd0);
        end
        for (int i = 0; i < 4; i++) begin
            step("dis_rel", 1'b0, 1'b0, 1'b0, 5'd20);
            chk("dis_rel_c", next_time, (i == 3) ? 5'd19 : 5'd20);
        end

        // Priority: rst+dis+stop clears, then stop passes 31 through
        step("prio_all", 1'b1, 1'b1, 1'b1, 5'd17);
        chk("prio_zero", next_time, 5'd0);
        for (int i = 0; i < 6; i++) begin
            step("prio_stop", 1'b0, 1'b0, 1'b1, 5'd31);
            chk("prio_31", next_time, 5'd31);
        end

        // Boundary: 0 on tick edge stays 0, 31 on tick edge gives 30
        step("bnd_clr", 1'b0, 1'b1, 1'b0, 5'd5);
        for (int i = 0; i < 3; i++) step("bnd_pre", 1'b0, 1'b0, 1'b0, 5'd5);
        step("bnd_zero", 1'b0, 1'b0, 1'b0, 5'd0);
        chk("bnd_zero_c", next_time, 5'd0);
        for (int i = 0; i < 3; i++) step("bnd_pre", 1'b0, 1'b0, 1'b0, 5'd7);
        step("bnd_31", 1'b0, 1'b0, 1'b0, 5'd31);
        chk("bnd_31_c", next_time, 5'd30);

        // Randomized traffic, alternating open-loop and feedback segments
        feedback = 1'b0;
        fb = 5'($urandom_range(0, 31));
        for (int i = 0; i < 1500; i++) begin
            if (i % 100 == 0) begin
                feedback = ~feedback;
                fb = 5'($urandom_range(0, 31));
            end
            r = ($urandom_range(0, 59) == 0);
            d = ($urandom_range(0, 24) == 0);
            s = ($urandom_range(0, 5) == 0);
            if (!feedback) fb = 5'($urandom_range(0, 31));
            step("random", r, d, s, fb);
            if (feedback) fb = exp_next;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/clock.md
Name: clock

Overview:
- Seconds-countdown step unit for the traffic-light controller.
- Divides the system clock down to a one-second tick.
- Each cycle, registers the next value of the remaining-time count from the externally held current value `rest_time`.
- The surrounding light FSM feeds `next_time` back into its own `rest_time` register; `stop` pauses timing and `dis` clears it.

Parameters:
- TICK_DIV, 100000000: system clock cycles per one-second tick. Legal range 2 to 2^27; a bench may override it with a small value such as 4.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous active-high reset.
- rest_time  input  5  current remaining seconds, 0..31, unsigned.
- next_time  output  5  registered next remaining-seconds value.
- stop  input  1  pause: holds the prescaler and suppresses decrement.
- dis  input  1  disable/clear: forces `next_time` to 0 and clears the prescaler.

Behaviour:
- State:
  - prescaler count `pcnt`, width ceil(log2(TICK_DIV)), range 0..TICK_DIV-1.
  - `next_time` register, 5 bits.
- Internal tick: `tick = (pcnt == TICK_DIV-1) && !stop && !dis`. Combinational, one clk cycle wide.
- Priority per rising edge, highest first: rst, dis, stop, normal.
- rst=1:
  - pcnt <= 0, next_time <= 0.
  - Applies regardless of the other inputs.
- dis=1 (rst=0):
  - pcnt <= 0, next_time <= 0.
  - Timing restarts from a full second after dis deasserts.
- stop=1 (rst=0, dis=0):
  - pcnt holds its value.
  - next_time <= rest_time (pass-through, no decrement).
- Normal (rst=0, dis=0, stop=0):
  - pcnt <= (pcnt == TICK_DIV-1) ? 0 : pcnt+1.
  - On tick: next_time <= (rest_time == 0) ? 0 : rest_time - 1. Saturates at 0; never wraps to 31.
  - Not on tick: next_time <= rest_time.
- Latency:
  - `next_time` reflects `rest_time` one clk edge later.
  - After reset or dis release, the first tick occurs on the TICK_DIV-th enabled edge.
  - Subsequent ticks occur every TICK_DIV enabled edges.
- Stop mid-second: the partial second is preserved. After stop deasserts, the tick fires after the remaining (TICK_DIV-1-pcnt)+1 edges.
- rest_time change on a tick edge: the decrement uses the value sampled at that edge.
- rest_time arithmetic: unsigned 5-bit. No other transformation is applied; 31 decrements to 30.
- No combinational path from any input to `next_time`.
- Power-up value before the first reset is undefined; a bench must assert rst before checking.

Test Plan:
- Reset: TICK_DIV=4, rst=1 for 2 cycles, rest_time=10.
  - Required: next_time=0 and pcnt=0 throughout reset.
  - After release: next_time=10 on edges 1-3; next_time=9 on edge 4; back to 10 on edges 5-7; 9 on edge 8.
- Feedback countdown: TICK_DIV=4, bench registers rest_time <= next_time, initial value 3.
  - Required: next_time steps 3→2→1→0 every 4 cycles, then stays 0 (saturation, no wrap to 31).
- Stop mid-second: TICK_DIV=4, rest_time=10. Assert stop after 2 enabled edges (pcnt=2) and hold it for 6 cycles.
  - Required: next_time=10 throughout stop.
  - After release: 9 appears on the 2nd edge.
- Disable: rest_time=20, dis=1 for 3 cycles.
  - Required: next_time=0 during dis.
  - After release: next_time=20, and the first 19 appears on the 4th edge (TICK_DIV=4).
- Priority: rst=1 and dis=1 with stop=1 together → next_time=0. Then rst=0, dis=0, stop=1, rest_time=31 → next_time=31, held with no decrement.
- Boundary: rest_time=0 on a tick edge → next_time=0. rest_time=31 on a tick edge → next_time=30.
